// File: rtl/spi_stream_writer_if.sv
// Write-side and serial-side signals of the LED-strip SPI stream writer.
// The slave modport is the writer itself; the master modport is the word producer.
interface spi_stream_writer_if #(
  parameter int WORD_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [WORD_WIDTH-1:0] spi_data_in;
  logic                  spi_write;
  logic                  spi_full;
  logic [CNT_W-1:0]      spi_fifo_count;
  logic                  spi_overflow;
  logic                  spi_output_data;
  logic                  spi_output_clock;
  logic                  spi_busy;

  modport master (
    output spi_data_in, spi_write,
    input  spi_full, spi_fifo_count, spi_overflow,
    input  spi_output_data, spi_output_clock, spi_busy
  );

  modport slave (
    input  spi_data_in, spi_write,
    output spi_full, spi_fifo_count, spi_overflow,
    output spi_output_data, spi_output_clock, spi_busy
  );
endinterface

// File: rtl/spi_stream_writer.sv
// Buffered SPI-style serialiser: words queue in a small FIFO and are shifted out
// back-to-back with a programmable clock half period, bit order and idle polarity.
module spi_stream_writer #(
  parameter int WORD_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int HALF_PERIOD = 6,
  parameter int LSB_FIRST   = 0,
  parameter int CPOL        = 0
) (
  input  logic               spi_clk,
  input  logic               spi_reset,
  spi_stream_writer_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PH_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD + 1) : 1;
  localparam int BIT_W = $clog2(WORD_WIDTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam logic             CPOL_LVL  = (CPOL != 0);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(HALF_PERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_WIDTH - 1);

  logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  logic                  full_reg;
  logic                  overflow_reg;

  logic [1:0]            state_reg;
  logic [PH_W-1:0]       phase_reg;
  logic [BIT_W-1:0]      bits_left_reg;
  logic [WORD_WIDTH-1:0] shift_reg;
  logic                  sclk_reg;
  logic                  sdata_reg;
  logic                  busy_reg;

  logic [WORD_WIDTH-1:0] head_word;
  logic [WORD_WIDTH-1:0] head_ordered;
  logic                  push;
  logic                  pop;
  logic                  fifo_ready;
  logic                  phase_done;

  assign fifo_ready = (count_reg != '0);
  assign phase_done = (phase_reg == PH_LAST);
  // full_reg is registered, so a write while full is refused even if a pop frees a slot this edge
  assign push       = bus.spi_write && !full_reg;
  assign pop        = fifo_ready &&
                      ((state_reg == ST_IDLE) ||
                       (state_reg == ST_ACTIVE && phase_done && bits_left_reg == '0));
  assign head_word  = mem[rd_ptr_reg];

  // Reorder the head word so the shifter always emits bit 0 first.
  generate
    for (genvar gi = 0; gi < WORD_WIDTH; gi++) begin : g_order
      if (LSB_FIRST != 0) begin : g_lsb
        assign head_ordered[gi] = head_word[gi];
      end else begin : g_msb
        assign head_ordered[gi] = head_word[WORD_WIDTH-1-gi];
      end
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge spi_clk) begin
    if (push && !spi_reset) begin
      mem[wr_ptr_reg] <= bus.spi_data_in;
    end
  end

  always_ff @(posedge spi_clk) begin
    if (spi_reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH_CNT);
      if (bus.spi_write && full_reg) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge spi_clk) begin
    if (spi_reset) begin
      state_reg     <= ST_IDLE;
      phase_reg     <= '0;
      bits_left_reg <= '0;
      shift_reg     <= '0;
      sclk_reg      <= CPOL_LVL;
      sdata_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          sclk_reg  <= CPOL_LVL;
          sdata_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
        ST_SETUP: begin
          if (phase_done) begin
            phase_reg <= '0;
            sclk_reg  <= ~CPOL_LVL;
            state_reg <= ST_ACTIVE;
          end else begin
            phase_reg <= phase_reg + PH_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (phase_done) begin
            phase_reg <= '0;
            sclk_reg  <= CPOL_LVL;
            if (bits_left_reg != '0) begin
              shift_reg     <= shift_reg >> 1;
              sdata_reg     <= shift_reg[1];
              bits_left_reg <= bits_left_reg - BIT_W'(1);
              state_reg     <= ST_SETUP;
            end else begin
              sdata_reg <= 1'b0;
              busy_reg  <= 1'b0;
              state_reg <= ST_IDLE;
            end
          end else begin
            phase_reg <= phase_reg + PH_W'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          phase_reg <= '0;
          sclk_reg  <= CPOL_LVL;
          sdata_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase

      // A pop (from IDLE or at the end of a word) overrides the paths above.
      if (pop) begin
        shift_reg     <= head_ordered;
        sdata_reg     <= head_ordered[0];
        bits_left_reg <= BIT_LAST;
        phase_reg     <= '0;
        busy_reg      <= 1'b1;
        state_reg     <= ST_SETUP;
      end
    end
  end

  assign bus.spi_full         = full_reg;
  assign bus.spi_fifo_count   = count_reg;
  assign bus.spi_overflow     = overflow_reg;
  assign bus.spi_output_data  = sdata_reg;
  assign bus.spi_output_clock = sclk_reg;
  assign bus.spi_busy         = busy_reg;
endmodule
